// File: rtl/reverse_hex_seq.sv
// reverse_hex_seq: reverses bit/nibble/byte units of a SIZE-bit word, one unit per clock.
// Optional stats port word_count enabled by `define REVERSE_HEX_STATS_EN.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake (ready only while idle)
//   in_data [0:SIZE-1]    input word, bit 0 = MSB
//   in_mode [1:0]         0 bit, 1 nibble, 2 byte, 3 pass-through
//   out_valid/out_ready   output handshake
//   out_data [0:SIZE-1]   reversed word, same bit ordering as in_data
//   busy                  high while shifting or holding a result
//   word_count [15:0]     output handshake count (stats build only)
module reverse_hex_seq #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef REVERSE_HEX_STATS_EN
  output logic [15:0]     word_count,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:SIZE-1] in_data,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:SIZE-1] out_data,
  output logic            busy
);

  localparam int CW = $clog2(SIZE + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] L_BIT  = CW'(SIZE - 1);
  localparam logic [CW-1:0] L_NIB  = CW'(SIZE / 4 - 1);
  localparam logic [CW-1:0] L_BYTE = CW'(SIZE / 8 - 1);
  localparam logic [CW-1:0] L_PASS = CW'(0);

  logic [1:0]      r_state;
  logic [1:0]      r_mode;
  logic [SIZE-1:0] r_src;
  logic [SIZE-1:0] r_dst;
  logic [CW-1:0]   r_cnt;

  logic [SIZE-1:0] w_src_nxt;
  logic [SIZE-1:0] w_dst_nxt;
  logic [CW-1:0]   w_last_idx;
  logic            w_last;

  // Pop the low unit of the source and push it into the low end of
  // the destination; the first unit popped ends up most significant.
  always_comb begin
    w_src_nxt  = r_src;
    w_dst_nxt  = r_dst;
    w_last_idx = L_PASS;
    unique case (r_mode)
      2'd0: begin
        w_src_nxt  = r_src >> 1;
        w_dst_nxt  = (r_dst << 1) | SIZE'(r_src[0]);
        w_last_idx = L_BIT;
      end
      2'd1: begin
        w_src_nxt  = r_src >> 4;
        w_dst_nxt  = (r_dst << 4) | SIZE'(r_src[3:0]);
        w_last_idx = L_NIB;
      end
      2'd2: begin
        w_src_nxt  = r_src >> 8;
        w_dst_nxt  = (r_dst << 8) | SIZE'(r_src[7:0]);
        w_last_idx = L_BYTE;
      end
      default: begin
        w_src_nxt  = '0;
        w_dst_nxt  = r_src;
        w_last_idx = L_PASS;
      end
    endcase
  end

  assign w_last = (r_cnt == w_last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 2'd0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_src   <= in_data;
            r_mode  <= in_mode;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_src <= w_src_nxt;
          r_dst <= w_dst_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign out_data  = r_dst;

`ifdef REVERSE_HEX_STATS_EN
  logic [15:0] r_word_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= 16'h0000;
    end else if (out_valid && out_ready) begin
      r_word_count <= r_word_count + 16'h0001;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_reverse_hex_seq.sv
// tb_reverse_hex_seq: scoreboard bench for reverse_hex_seq.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_reverse_hex_seq;

  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid;
  logic            in_ready;
  logic [0:SIZE-1] in_data;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [0:SIZE-1] out_data;
  logic            busy;
`ifdef REVERSE_HEX_STATS_EN
  logic [15:0]     word_count;
  logic [15:0]     exp_wc = 16'h0000;
`endif

  reverse_hex_seq #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef REVERSE_HEX_STATS_EN
    .word_count(word_count),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] exp;
    int              acc;
    int              units;
  } item_t;

  item_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  bit    prev_valid = 1'b0;
  bit    prev_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int units_of(input logic [1:0] m);
    case (m)
      2'd0:    return SIZE;
      2'd1:    return SIZE / 4;
      2'd2:    return SIZE / 8;
      default: return 1;
    endcase
  endfunction

  // Reference: split into units, unit i from the LSB end lands at
  // position U-1-i from the LSB end.
  function automatic logic [SIZE-1:0] model(input logic [SIZE-1:0] d,
                                            input logic [1:0] m);
    int u = units_of(m);
    int w = SIZE / u;
    logic [SIZE-1:0] mask = {SIZE{1'b1}} >> (SIZE - w);
    logic [SIZE-1:0] r = '0;
    logic [SIZE-1:0] unit;
    for (int i = 0; i < u; i++) begin
      unit = (d >> (i * w)) & mask;
      r = r | (unit << ((u - 1 - i) * w));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs = 1'b0;
`ifdef REVERSE_HEX_STATS_EN
      exp_wc = 16'h0000;
`endif
    end else begin
`ifdef REVERSE_HEX_STATS_EN
      check("word_count", word_count, exp_wc);
`endif
      if (prev_hs) begin
        check("ready_after_hs", in_ready, 1);
        check("valid_drop", out_valid, 0);
      end
      prev_hs = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          if (!prev_valid)
            check("latency", cyc - q[0].acc, q[0].units + 1);
          check("out_data", out_data, q[0].exp);
          check("in_ready_in_done", in_ready, 0);
          check("busy_in_done", busy, 1);
          if (out_ready) begin
            void'(q.pop_front());
            prev_hs = 1'b1;
`ifdef REVERSE_HEX_STATS_EN
            exp_wc = exp_wc + 16'h0001;
`endif
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [SIZE-1:0] d, input logic [1:0] m,
                      input bit chg, input bit use_exp,
                      input logic [SIZE-1:0] e);
    int n = 0;
    item_t it;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(posedge clk); #1;
    it.exp   = use_exp ? e : model(d, m);
    it.units = units_of(m);
    it.acc   = cyc - 1;
    q.push_back(it);
    in_valid = 1'b0;
    in_data  = SIZE'($urandom);
    in_mode  = chg ? 2'd0 : 2'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || !in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: pending %0d expected 0", q.size());
    end
  endtask

  initial begin
    int n;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'habcd, 2'd1, 1'b0, 1'b1, 16'hdcba);
    send(16'hacef, 2'd1, 1'b0, 1'b1, 16'hfeca);
    send(16'habcd, 2'd2, 1'b0, 1'b1, 16'hcdab);
    send(16'habcd, 2'd0, 1'b0, 1'b1, 16'hb3d5);
    send(16'h1234, 2'd3, 1'b0, 1'b1, 16'h1234);
    send(16'h5a3c, 2'd1, 1'b1, 1'b1, 16'hc3a5);
    wait_idle();

    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(16'h1357, 2'd2, 1'b0, 1'b1, 16'h5713);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", out_valid, 1);
    repeat (5) begin
      in_valid = 1'b1;
      in_data  = 16'hffff;
      in_mode  = 2'd3;
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();

    rdy_mode = 1;
    repeat (40)
      send(SIZE'($urandom), 2'($urandom), 1'($urandom), 1'b0, '0);
    rdy_mode = 0;
    wait_idle();

    send(16'hffff, 2'd0, 1'b0, 1'b1, 16'hffff);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("post_rst_idle", in_ready, 1);

    send(16'habcd, 2'd1, 1'b0, 1'b1, 16'hdcba);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
